// File: rtl/cmp_shift_harness.sv
// cmp_shift_harness: serial-load operand shifter, settle/capture and bit-serial result readout for compressor trees.
// Optional running signature output enabled by CMP_HARNESS_SIG_EN.
module cmp_shift_harness #(
  parameter int N_SRC  = 16,
  parameter int SRC_W  = 16,
  parameter int N_DST  = 20,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   shift_en,
  input  logic [N_SRC-1:0]       src_in,
  output logic [N_SRC*SRC_W-1:0] src_bus,
  input  logic [N_DST-1:0]       dst_bus,
  output logic                   fill_done,
  output logic                   cap_valid,
  output logic [N_DST-1:0]       cap_data,
  output logic                   dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   busy
`ifdef CMP_HARNESS_SIG_EN
  ,output logic [N_DST-1:0]      sig
`endif
);
  // One counter serves fill, settle and drain phases; sized for the longest.
  localparam int MAX_A = SRC_W > SETTLE ? SRC_W : SETTLE;
  localparam int MAXC  = MAX_A > N_DST ? MAX_A : N_DST;
  localparam int CW    = $clog2(MAXC + 1);
  typedef enum logic [1:0] {S_FILL, S_SETTLE, S_DRAIN} state_t;
  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [N_SRC*SRC_W-1:0]   src_q, src_d;
  logic [N_DST-1:0]         cap_q, cap_d;
  logic                     cap_valid_q, cap_valid_d;
  logic [N_DST-1:0]         cap_sh;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    src_d       = src_q;
    cap_d       = cap_q;
    cap_valid_d = 1'b0;
    case (state_q)
      S_FILL: if (shift_en) begin
        for (int k = 0; k < N_SRC; k++)
          src_d[k*SRC_W +: SRC_W] = {src_q[k*SRC_W +: SRC_W-1], src_in[k]};
        cnt_d   = cnt_q == CW'(SRC_W - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(SRC_W - 1) ? S_SETTLE : S_FILL;
      end
      S_SETTLE: begin
        cnt_d       = cnt_q == CW'(SETTLE - 1) ? '0 : cnt_q + 1'b1;
        state_d     = cnt_q == CW'(SETTLE - 1) ? S_DRAIN : S_SETTLE;
        cap_d       = cnt_q == CW'(SETTLE - 1) ? dst_bus : cap_q;
        cap_valid_d = cnt_q == CW'(SETTLE - 1);
      end
      S_DRAIN: if (dout_ready) begin
        cnt_d   = cnt_q == CW'(N_DST - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(N_DST - 1) ? S_FILL : S_DRAIN;
      end
      default: state_d = S_FILL;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      cnt_q       <= '0;
      src_q       <= '0;
      cap_q       <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src_q       <= src_d;
      cap_q       <= cap_d;
      cap_valid_q <= cap_valid_d;
    end
  end
`ifdef CMP_HARNESS_SIG_EN
  logic [N_DST-1:0] sig_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= '0;
    else if (cap_valid_d) sig_q <= {sig_q[N_DST-2:0], sig_q[N_DST-1]} ^ dst_bus;
  end
  assign sig = sig_q;
`endif
  // Shift instead of a variable bit-select keeps the index width-agnostic.
  assign cap_sh     = cap_q >> cnt_q;
  assign src_bus    = src_q;
  assign cap_data   = cap_q;
  assign cap_valid  = cap_valid_q;
  assign fill_done  = state_q == S_SETTLE;
  assign dout_valid = state_q == S_DRAIN;
  assign dout       = state_q == S_DRAIN ? cap_sh[0] : 1'b0;
  assign busy       = state_q != S_FILL;
endmodule

// File: tb/tb_cmp_shift_harness.sv
// tb_cmp_shift_harness: directed and random runs of cmp_shift_harness against a bit-history operand model.
module tb_cmp_shift_harness;
  localparam int N_SRC = 16, SRC_W = 16, N_DST = 20, SETTLE = 2;
  logic clk = 0, rst = 0, shift_en = 0, dout_ready = 0;
  logic [N_SRC-1:0] src_in = '0;
  logic [N_SRC*SRC_W-1:0] src_bus;
  logic [N_DST-1:0] dst_bus, cap_data, exp_cap;
  logic fill_done, cap_valid, dout, dout_valid, busy;
  logic [SRC_W-1:0] exp_op [N_SRC];
  logic [SRC_W-1:0] pat;
  int total = 0, bad = 0, cyc, sa, sl;
`ifdef CMP_HARNESS_SIG_EN
  logic [N_DST-1:0] sig, exp_sig = '0;
`endif
  cmp_shift_harness #(.N_SRC(N_SRC), .SRC_W(SRC_W), .N_DST(N_DST), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .shift_en(shift_en), .src_in(src_in), .src_bus(src_bus),
    .dst_bus(dst_bus), .fill_done(fill_done), .cap_valid(cap_valid), .cap_data(cap_data),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy)
`ifdef CMP_HARNESS_SIG_EN
    , .sig(sig)
`endif
  );
  always #5 clk = ~clk;
  // Compressor under test: plain sum of all operands.
  always_comb begin
    dst_bus = '0;
    for (int i = 0; i < N_SRC; i++) dst_bus = dst_bus + N_DST'(src_bus[i*SRC_W +: SRC_W]);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clear_model();
    for (int i = 0; i < N_SRC; i++) exp_op[i] = '0;
`ifdef CMP_HARNESS_SIG_EN
    exp_sig = '0;
`endif
  endtask
  function automatic logic [N_DST-1:0] model_sum();
    logic [N_DST-1:0] s = '0;
    for (int i = 0; i < N_SRC; i++) s = s + N_DST'(exp_op[i]);
    return s;
  endfunction
  task automatic push(input logic [N_SRC-1:0] lanes);
    src_in = lanes;
    shift_en = 1;
    @(negedge clk);
    shift_en = 0;
    for (int i = 0; i < N_SRC; i++) exp_op[i] = {exp_op[i][SRC_W-2:0], lanes[i]};
  endtask
  task automatic check_ops(input string tag);
    for (int i = 0; i < N_SRC; i++)
      chk($sformatf("%s op%0d", tag, i), src_bus[i*SRC_W +: SRC_W], exp_op[i]);
  endtask
  task automatic settle_capture();
    for (int k = 0; k < SETTLE; k++) begin
      chk("fill_done settle", fill_done, 1);
      chk("busy settle", busy, 1);
      chk("cap_valid early", cap_valid, 0);
      shift_en = 1;
      src_in = N_SRC'($urandom);
      @(negedge clk);
      shift_en = 0;
    end
    exp_cap = model_sum();
    chk("fill_done drop", fill_done, 0);
    chk("cap_valid pulse", cap_valid, 1);
    chk("dout_valid", dout_valid, 1);
    chk("cap_data", cap_data, exp_cap);
    check_ops("frozen");
`ifdef CMP_HARNESS_SIG_EN
    exp_sig = {exp_sig[N_DST-2:0], exp_sig[N_DST-1]} ^ exp_cap;
    chk("sig", sig, exp_sig);
`endif
  endtask
  task automatic fill_rand();
    for (int k = 0; k < SRC_W; k++) push(N_SRC'($urandom));
    check_ops("rand fill");
  endtask
  task automatic drain(input int nb, input int stall_at, input int stall_len, output int cycles);
    cycles = 0;
    for (int b = 0; b < nb; b++) begin
      dout_ready = 0;
      if (b == stall_at) repeat (stall_len) begin
        chk("dout hold", dout, exp_cap[b]);
        chk("valid hold", dout_valid, 1);
        cycles++;
        @(negedge clk);
      end
      chk($sformatf("dout b%0d", b), dout, exp_cap[b]);
      chk("cap_valid once", cap_valid, cycles == 0);
      dout_ready = 1;
      cycles++;
      @(negedge clk);
    end
    dout_ready = 0;
    if (nb == N_DST) begin
      chk("busy end", busy, 0);
      chk("dout_valid end", dout_valid, 0);
    end
  endtask
  initial begin
    #3 rst = 1;
    #1;
    chk("rst busy", busy, 0);
    chk("rst src_bus", src_bus, 0);
    chk("rst cap_data", cap_data, 0);
    chk("rst outs", {fill_done, cap_valid, dout, dout_valid}, 0);
    @(negedge clk);
    rst = 0;
    clear_model();
    // All-ones fill
    for (int k = 0; k < SRC_W; k++) push('1);
    check_ops("ones");
    chk("ones op0", src_bus[SRC_W-1:0], 16'hFFFF);
    settle_capture();
    chk("ones cap", cap_data, 20'hFFFF0);
    drain(N_DST, -1, 0, cyc);
    chk("ones drain len", cyc, N_DST);
    // Lane 0 pattern with a 5-cycle pause after shift 7
    pat = 16'hA5C3;
    for (int k = 0; k < SRC_W; k++) begin
      push({{(N_SRC-1){1'b0}}, pat[SRC_W-1-k]});
      if (k == 6) repeat (5) begin
        src_in = N_SRC'($urandom);
        chk("pause busy", busy, 0);
        chk("pause fill_done", fill_done, 0);
        @(negedge clk);
      end
    end
    check_ops("pat");
    chk("pat op0", src_bus[SRC_W-1:0], 16'hA5C3);
    settle_capture();
    chk("pat cap", cap_data, 20'h0A5C3);
    drain(N_DST, 5, 3, cyc);
    chk("stall drain len", cyc, 23);
    // Back-to-back random runs with random backpressure
    repeat (4) begin
      fill_rand();
      settle_capture();
      sa = $urandom_range(0, N_DST - 1);
      sl = $urandom_range(0, 4);
      drain(N_DST, sa, sl, cyc);
      chk("rand drain len", cyc, N_DST + sl);
    end
    // Reset in the middle of a drain
    fill_rand();
    settle_capture();
    drain(10, -1, 0, cyc);
    chk("mid busy", busy, 1);
    #2 rst = 1;
    #1;
    chk("mid rst busy", busy, 0);
    chk("mid rst dout_valid", dout_valid, 0);
    chk("mid rst dout", dout, 0);
    chk("mid rst cap", cap_data, 0);
    chk("mid rst src", src_bus, 0);
    @(negedge clk);
    rst = 0;
    clear_model();
    fill_rand();
    settle_capture();
    drain(N_DST, $urandom_range(0, N_DST - 1), 2, cyc);
    chk("post rst drain len", cyc, N_DST + 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
